icache_mem_arb: RTL and testbench

Arbitrates the nibble-serial external memory port between instruction-cache line refills and data-side loads/stores. Refills are collected in a line buffer, then replayed to the icache as one unbroken burst of nibble strobes, because the icache fill counter restarts whenever its strobe drops. The block sits between the core's fetch/load-store units, the icache fill port, and the memory interface.

---
 rtl/vc16_mem_pkg.sv | 53 +++++
 rtl/mem_nibble_buf.sv | 44 ++++
 rtl/icache_mem_arb.sv | 209 ++++++++++++++++++++
 tb/tb_icache_mem_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc16_mem_pkg.sv
// Shared types and nibble-order helpers for the nibble-serial memory port.
package vc16_mem_pkg;

  localparam int unsigned PA          = 22;
  localparam int unsigned RV          = 16;
  localparam int unsigned LINE_LENGTH = 4;
  localparam int unsigned LINE_OFF_W  = $clog2(LINE_LENGTH);
  localparam int unsigned TAG_W       = PA - LINE_OFF_W;
  localparam int unsigned BUF_W       = 32;
  localparam int unsigned PTR_W       = 3;
  localparam int unsigned LEN_W       = 4;

  localparam logic [LEN_W-1:0] NIBBLES_LINE = LEN_W'(LINE_LENGTH * 2);
  localparam logic [LEN_W-1:0] NIBBLES_WORD = LEN_W'(4);
  localparam logic [LEN_W-1:0] NIBBLES_BYTE = LEN_W'(2);

  typedef enum logic [2:0] {IDLE, CMD, RD, WR, REPLAY} state_e;

  typedef struct packed {
    logic [PA-1:0]    addr;
    logic             write;
    logic [LEN_W-1:0] len;
  } mem_cmd_t;

  // Nibble i lives in byte i/2; even nibbles are the high half of that byte.
  function automatic logic [4:0] nib_lsb(input logic [PTR_W-1:0] idx);
    return {idx[2:1], ~idx[0], 2'b00};
  endfunction

  function automatic logic [3:0] nib_get(input logic [BUF_W-1:0] data,
                                         input logic [PTR_W-1:0] idx);
    return data[nib_lsb(idx) +: 4];
  endfunction

  function automatic logic [BUF_W-1:0] nib_put(input logic [BUF_W-1:0] data,
                                               input logic [PTR_W-1:0] idx,
                                               input logic [3:0]       nib);
    logic [BUF_W-1:0] res;
    res = data;
    res[nib_lsb(idx) +: 4] = nib;
    return res;
  endfunction

  function automatic logic [RV-1:0] word_put(input logic [RV-1:0] word,
                                             input logic [1:0]    idx,
                                             input logic [3:0]    nib);
    logic [RV-1:0] res;
    res = word;
    res[4'({idx[1], ~idx[0], 2'b00}) +: 4] = nib;
    return res;
  endfunction

endpackage

// File: rtl/mem_nibble_buf.sv
// 32-bit nibble buffer: sequential capture via write pointer, sequential emit via read pointer.
module mem_nibble_buf
  import vc16_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_data,
  input  logic             wr_en,
  input  logic [3:0]       wr_nib,
  input  logic             rd_adv,
  output logic [RV-1:0]    word,
  output logic [3:0]       rd_nib_c
);

  logic [BUF_W-1:0] data;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // A load starts a new transaction: fresh contents, both pointers rewound.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (load) begin
      data   <= load_data;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        data   <= nib_put(data, wr_ptr, wr_nib);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign word     = data[RV-1:0];
  assign rd_nib_c = nib_get(data, rd_ptr);

endmodule

// File: rtl/icache_mem_arb.sv
// Arbitrates the nibble-serial memory port between icache line refills and data loads/stores;
// refills are buffered and replayed to the icache as one gap-free strobe burst.
module icache_mem_arb
  import vc16_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_pull,
  input  logic [TAG_W-1:0] ic_tag,
  output logic [3:0]       ic_dread,
  output logic             ic_wstrobe_d,
  output logic             ic_fill_busy,
  input  logic             d_req,
  input  logic             d_write,
  input  logic             d_byte,
  input  logic [PA-1:0]    d_addr,
  input  logic [RV-1:0]    d_wdata,
  output logic [RV-1:0]    d_rdata,
  output logic             d_done,
  output logic             mem_cmd_valid,
  input  logic             mem_cmd_ready,
  output logic [PA-1:0]    mem_addr,
  output logic             mem_write,
  output logic [LEN_W-1:0] mem_len,
  input  logic             mem_rvalid,
  input  logic [3:0]       mem_rdata,
  input  logic             mem_wready,
  output logic [3:0]       mem_wdata
);

  state_e           state_q, state_nxt;
  logic             prio_q, prio_nxt;
  logic [LEN_W-1:0] cnt_q, cnt_nxt;
  mem_cmd_t         cmd_q, cmd_nxt;
  logic             is_ic_q, is_ic_nxt;
  logic             cmd_valid_nxt;
  logic [3:0]       ic_dread_nxt;
  logic             ic_wstrobe_nxt;
  logic             fill_busy_nxt;
  logic [RV-1:0]    d_rdata_nxt;
  logic             d_done_nxt;
  logic [3:0]       mem_wdata_nxt;

  logic             buf_load_c, buf_wr_c, buf_rd_adv_c;
  logic [BUF_W-1:0] buf_load_data_c;
  logic [RV-1:0]    buf_word;
  logic [3:0]       buf_nib_c;
  logic [RV-1:0]    rd_word_c;
  logic             d_req_c, grant_ic_c, grant_d_c, last_c;

  mem_nibble_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load_c),
    .load_data (buf_load_data_c),
    .wr_en     (buf_wr_c),
    .wr_nib    (mem_rdata),
    .rd_adv    (buf_rd_adv_c),
    .word      (buf_word),
    .rd_nib_c  (buf_nib_c)
  );

  // d_req is still high in the d_done cycle; masking it there avoids re-issuing the same access.
  assign d_req_c    = d_req && !d_done;
  assign grant_ic_c = ic_pull && (!d_req_c || prio_q);
  assign grant_d_c  = d_req_c && !grant_ic_c;
  assign last_c     = (cnt_q == cmd_q.len - LEN_W'(1));
  assign rd_word_c  = word_put(buf_word, cnt_q[1:0], mem_rdata);

  assign mem_addr  = cmd_q.addr;
  assign mem_write = cmd_q.write;
  assign mem_len   = cmd_q.len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      cnt_q         <= '0;
      cmd_q         <= '0;
      is_ic_q       <= 1'b0;
      mem_cmd_valid <= 1'b0;
      ic_dread      <= '0;
      ic_wstrobe_d  <= 1'b0;
      ic_fill_busy  <= 1'b0;
      d_rdata       <= '0;
      d_done        <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      state_q       <= state_nxt;
      prio_q        <= prio_nxt;
      cnt_q         <= cnt_nxt;
      cmd_q         <= cmd_nxt;
      is_ic_q       <= is_ic_nxt;
      mem_cmd_valid <= cmd_valid_nxt;
      ic_dread      <= ic_dread_nxt;
      ic_wstrobe_d  <= ic_wstrobe_nxt;
      ic_fill_busy  <= fill_busy_nxt;
      d_rdata       <= d_rdata_nxt;
      d_done        <= d_done_nxt;
      mem_wdata     <= mem_wdata_nxt;
    end
  end

  // Next state and next registered outputs; the buffer read pointer runs one nibble ahead of the
  // registered nibble outputs so each emitted nibble is already selected when it is registered.
  always_comb begin
    state_nxt       = state_q;
    prio_nxt        = prio_q;
    cnt_nxt         = cnt_q;
    cmd_nxt         = cmd_q;
    is_ic_nxt       = is_ic_q;
    cmd_valid_nxt   = mem_cmd_valid;
    ic_dread_nxt    = '0;
    ic_wstrobe_nxt  = 1'b0;
    fill_busy_nxt   = ic_fill_busy;
    d_rdata_nxt     = d_rdata;
    d_done_nxt      = 1'b0;
    mem_wdata_nxt   = mem_wdata;
    buf_load_c      = 1'b0;
    buf_load_data_c = '0;
    buf_wr_c        = 1'b0;
    buf_rd_adv_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ic_c || grant_d_c) begin
          state_nxt     = CMD;
          cmd_valid_nxt = 1'b1;
          cnt_nxt       = '0;
          buf_load_c    = 1'b1;
          prio_nxt      = grant_d_c;
          is_ic_nxt     = grant_ic_c;
          fill_busy_nxt = grant_ic_c;
          if (grant_ic_c) begin
            cmd_nxt.addr  = {ic_tag, {LINE_OFF_W{1'b0}}};
            cmd_nxt.write = 1'b0;
            cmd_nxt.len   = NIBBLES_LINE;
            mem_wdata_nxt = '0;
          end else begin
            cmd_nxt.addr  = d_addr;
            cmd_nxt.write = d_write;
            cmd_nxt.len   = d_byte ? NIBBLES_BYTE : NIBBLES_WORD;
            mem_wdata_nxt = d_write ? d_wdata[7:4] : 4'h0;
            if (d_write) begin
              buf_load_data_c = d_byte ? BUF_W'(d_wdata[7:0]) : BUF_W'(d_wdata);
            end
          end
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          cmd_valid_nxt = 1'b0;
          if (cmd_q.write) begin
            state_nxt    = WR;
            buf_rd_adv_c = 1'b1;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        if (mem_rvalid) begin
          buf_wr_c = 1'b1;
          cnt_nxt  = cnt_q + LEN_W'(1);
          if (last_c) begin
            cnt_nxt = '0;
            if (is_ic_q) begin
              state_nxt      = REPLAY;
              ic_wstrobe_nxt = 1'b1;
              ic_dread_nxt   = buf_nib_c;
              buf_rd_adv_c   = 1'b1;
            end else begin
              state_nxt   = IDLE;
              d_done_nxt  = 1'b1;
              d_rdata_nxt = (cmd_q.len == NIBBLES_BYTE) ? {8'h00, rd_word_c[7:0]} : rd_word_c;
            end
          end
        end
      end
      WR: begin
        if (mem_wready) begin
          cnt_nxt       = cnt_q + LEN_W'(1);
          mem_wdata_nxt = buf_nib_c;
          buf_rd_adv_c  = 1'b1;
          if (last_c) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            d_done_nxt    = 1'b1;
            mem_wdata_nxt = '0;
          end
        end
      end
      REPLAY: begin
        if (cnt_q == NIBBLES_LINE - LEN_W'(1)) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          fill_busy_nxt = 1'b0;
        end else begin
          ic_wstrobe_nxt = 1'b1;
          ic_dread_nxt   = buf_nib_c;
          buf_rd_adv_c   = 1'b1;
          cnt_nxt        = cnt_q + LEN_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_mem_arb.sv
// Directed self-checking bench for icache_mem_arb.
module tb_icache_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_pull;
  logic [19:0] ic_tag;
  logic [3:0]  ic_dread;
  logic        ic_wstrobe_d;
  logic        ic_fill_busy;
  logic        d_req, d_write, d_byte;
  logic [21:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        mem_cmd_valid, mem_cmd_ready;
  logic [21:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_len;
  logic        mem_rvalid;
  logic [3:0]  mem_rdata;
  logic        mem_wready;
  logic [3:0]  mem_wdata;

  int checks = 0;
  int errors = 0;

  wire [54:0] all_out = {ic_dread, ic_wstrobe_d, ic_fill_busy, d_rdata, d_done,
                         mem_cmd_valid, mem_addr, mem_write, mem_len, mem_wdata};

  always #5 clk = ~clk;

  icache_mem_arb dut (
    .clk           (clk),
    .reset         (reset),
    .ic_pull       (ic_pull),
    .ic_tag        (ic_tag),
    .ic_dread      (ic_dread),
    .ic_wstrobe_d  (ic_wstrobe_d),
    .ic_fill_busy  (ic_fill_busy),
    .d_req         (d_req),
    .d_write       (d_write),
    .d_byte        (d_byte),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_rdata       (d_rdata),
    .d_done        (d_done),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_addr      (mem_addr),
    .mem_write     (mem_write),
    .mem_len       (mem_len),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_wready    (mem_wready),
    .mem_wdata     (mem_wdata)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ic_pull = 0; ic_tag = '0; d_req = 0; d_write = 0; d_byte = 0; d_addr = '0; d_wdata = '0;
    mem_cmd_ready = 0; mem_rvalid = 0; mem_rdata = '0; mem_wready = 0;
  endtask

  task automatic pulse_reset();
    reset = 0; cyc(); reset = 1; cyc();
  endtask

  task automatic test_reset();
    reset = 0; idle_inputs();
    repeat (2) cyc();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
    reset = 1; cyc(); cyc();
    checks++;
    if (mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL idle_no_cmd got %b want 0", mem_cmd_valid); end
  endtask

  task automatic test_refill();
    int gaps[8] = '{0, 1, 2, 3, 0, 2, 1, 3};
    logic [3:0] nibs[8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
    logic [31:0] line;
    int n, runs, early;
    logic prev;
    ic_tag = 20'h01234; ic_pull = 1; cyc();
    checks++;
    if ({mem_cmd_valid, mem_write, mem_len, ic_fill_busy} !== {1'b1, 1'b0, 4'd8, 1'b1}) begin
      errors++; $display("FAIL refill_cmd got v%b w%b len%0d busy%b want v1 w0 len8 busy1",
                         mem_cmd_valid, mem_write, mem_len, ic_fill_busy);
    end
    checks++;
    if (mem_addr !== 22'h0048D0) begin errors++; $display("FAIL refill_addr got %h want 0048d0", mem_addr); end
    mem_cmd_ready = 1; cyc(); mem_cmd_ready = 0;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        mem_rvalid = 0; cyc();
        if (ic_wstrobe_d) early++;
      end
      mem_rvalid = 1; mem_rdata = nibs[i]; cyc();
      if (i < 7 && ic_wstrobe_d) early++;
    end
    mem_rvalid = 0; mem_rdata = '0;
    line = '0; n = 0; runs = 0; prev = 0;
    for (int c = 0; c < 20; c++) begin
      if (ic_wstrobe_d) begin
        if (!prev) runs++;
        if (n < 8) line[(n / 2) * 8 + (((n % 2) == 1) ? 0 : 4) +: 4] = ic_dread;
        n++;
        if (n == 8) ic_pull = 0;
      end
      prev = ic_wstrobe_d;
      cyc();
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL refill_early_strobe got %0d want 0", early); end
    checks++;
    if (n != 8) begin errors++; $display("FAIL refill_strobe_count got %0d want 8", n); end
    checks++;
    if (runs != 1) begin errors++; $display("FAIL refill_contiguous got %0d runs want 1", runs); end
    checks++;
    if (line !== 32'h44332211) begin errors++; $display("FAIL refill_line got %h want 44332211", line); end
    checks++;
    if ({ic_fill_busy, mem_cmd_valid} !== 2'b00) begin
      errors++; $display("FAIL refill_after got busy%b v%b want 0 0", ic_fill_busy, mem_cmd_valid);
    end
  endtask

  task automatic test_data_load();
    logic [3:0] wn[4] = '{4'hB, 4'h2, 4'hA, 4'h1};
    d_addr = 22'h000102; d_write = 0; d_byte = 0; d_req = 1; cyc();
    checks++;
    if ({mem_cmd_valid, mem_write, mem_len} !== {1'b1, 1'b0, 4'd4} || mem_addr !== 22'h000102) begin
      errors++; $display("FAIL load_cmd got v%b w%b len%0d a%h want v1 w0 len4 a000102",
                         mem_cmd_valid, mem_write, mem_len, mem_addr);
    end
    mem_cmd_ready = 1; cyc(); mem_cmd_ready = 0;
    for (int i = 0; i < 4; i++) begin mem_rvalid = 1; mem_rdata = wn[i]; cyc(); end
    mem_rvalid = 0;
    checks++;
    if (d_done !== 1'b1 || d_rdata !== 16'hA1B2) begin
      errors++; $display("FAIL load_word got done%b %h want done1 a1b2", d_done, d_rdata);
    end
    d_req = 0; cyc();
    checks++;
    if (d_done !== 1'b0) begin errors++; $display("FAIL load_single_done got %b want 0", d_done); end

    d_addr = 22'h000103; d_byte = 1; d_req = 1; cyc();
    checks++;
    if (mem_len !== 4'd2 || mem_addr !== 22'h000103 || mem_cmd_valid !== 1'b1) begin
      errors++; $display("FAIL load_byte_cmd got len%0d a%h want len2 a000103", mem_len, mem_addr);
    end
    mem_cmd_ready = 1; cyc(); mem_cmd_ready = 0;
    for (int i = 0; i < 2; i++) begin mem_rvalid = 1; mem_rdata = 4'hF; cyc(); end
    mem_rvalid = 0;
    checks++;
    if (d_done !== 1'b1 || d_rdata !== 16'h00FF) begin
      errors++; $display("FAIL load_byte got done%b %h want done1 00ff", d_done, d_rdata);
    end
    d_req = 0; d_byte = 0; cyc();
  endtask

  task automatic test_word_store();
    logic [3:0] exp[4] = '{4'hB, 4'h2, 4'hA, 4'h1};
    int stalls[4] = '{2, 0, 3, 1};
    d_addr = 22'h000200; d_wdata = 16'hA1B2; d_write = 1; d_byte = 0; d_req = 1; cyc();
    checks++;
    if ({mem_cmd_valid, mem_write, mem_len} !== {1'b1, 1'b1, 4'd4} || mem_addr !== 22'h000200) begin
      errors++; $display("FAIL store_cmd got v%b w%b len%0d a%h want v1 w1 len4 a000200",
                         mem_cmd_valid, mem_write, mem_len, mem_addr);
    end
    mem_cmd_ready = 1; cyc(); mem_cmd_ready = 0;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < stalls[i]; s++) begin
        mem_wready = 0;
        checks++;
        if (mem_wdata !== exp[i] || d_done !== 1'b0) begin
          errors++; $display("FAIL store_stall%0d got %h done%b want %h done0", i, mem_wdata, d_done, exp[i]);
        end
        cyc();
      end
      checks++;
      if (mem_wdata !== exp[i] || d_done !== 1'b0) begin
        errors++; $display("FAIL store_nib%0d got %h done%b want %h done0", i, mem_wdata, d_done, exp[i]);
      end
      mem_wready = 1; cyc();
    end
    mem_wready = 0;
    checks++;
    if (d_done !== 1'b1) begin errors++; $display("FAIL store_done got %b want 1", d_done); end
    d_req = 0; d_write = 0; cyc();
    checks++;
    if (d_done !== 1'b0) begin errors++; $display("FAIL store_single_done got %b want 0", d_done); end
  endtask

  task automatic test_cmd_stall();
    logic [3:0] wn[4] = '{4'h5, 4'h6, 4'h7, 4'h8};
    d_addr = 22'h000ABE; d_write = 0; d_byte = 0; d_req = 1; mem_cmd_ready = 0; cyc();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({mem_cmd_valid, mem_len} !== {1'b1, 4'd4} || mem_addr !== 22'h000ABE) begin
        errors++; $display("FAIL stall_cmd%0d got v%b len%0d a%h want v1 len4 a000abe",
                           c, mem_cmd_valid, mem_len, mem_addr);
      end
      mem_rvalid = 1; mem_rdata = 4'hE; cyc();
    end
    mem_rvalid = 0; mem_cmd_ready = 1; cyc(); mem_cmd_ready = 0;
    for (int i = 0; i < 4; i++) begin mem_rvalid = 1; mem_rdata = wn[i]; cyc(); end
    mem_rvalid = 0;
    checks++;
    if (d_done !== 1'b1 || d_rdata !== 16'h7856) begin
      errors++; $display("FAIL stall_data got done%b %h want done1 7856", d_done, d_rdata);
    end
    d_req = 0; cyc();
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_len[4] = '{4'd4, 4'd8, 4'd4, 4'd8};
    int grants, t_grant;
    logic prev;
    bit done;
    pulse_reset();
    grants = 0; t_grant = 0; prev = 0; done = 0;
    d_addr = 22'h000300; d_write = 0; d_byte = 0; ic_tag = 20'h00040;
    d_req = 1; ic_pull = 1; mem_cmd_ready = 1; mem_rvalid = 1; mem_rdata = 4'h9;
    for (int t = 0; t < 300 && !done; t++) begin
      cyc();
      if (mem_cmd_valid) begin
        if (grants < 4) begin
          checks++;
          if (mem_len !== exp_len[grants]) begin
            errors++; $display("FAIL arb_grant%0d got len%0d want len%0d", grants, mem_len, exp_len[grants]);
          end
        end
        grants++; t_grant = t;
        if (grants == 4) begin d_req = 0; ic_pull = 0; end
      end
      if (d_done) begin
        checks++;
        if (t - t_grant != 5) begin errors++; $display("FAIL arb_load_latency got %0d want 5", t - t_grant); end
      end
      if (ic_wstrobe_d && !prev) begin
        checks++;
        if (t - t_grant != 9) begin errors++; $display("FAIL arb_refill_latency got %0d want 9", t - t_grant); end
      end
      prev = ic_wstrobe_d;
      if (grants >= 4 && !ic_fill_busy) done = 1;
    end
    checks++;
    if (!done || grants != 4) begin errors++; $display("FAIL arb_timeout got %0d grants want 4", grants); end
    idle_inputs(); cyc();
  endtask

  task automatic test_reset_mid_replay();
    int n;
    bit hit;
    n = 0; hit = 0;
    ic_tag = 20'h00ABC; ic_pull = 1; mem_cmd_ready = 1; mem_rvalid = 1; mem_rdata = 4'h7;
    for (int c = 0; c < 40 && !hit; c++) begin
      cyc();
      if (ic_wstrobe_d) begin n++; if (n == 5) hit = 1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_replay_timeout got %0d strobes want 5", n); end
    reset = 0; #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL mid_replay_reset got %h want 0", all_out); end
    cyc(); reset = 1; mem_rdata = 4'h3; cyc();
    checks++;
    if ({mem_cmd_valid, mem_len} !== {1'b1, 4'd8} || mem_addr !== 22'h002AF0) begin
      errors++; $display("FAIL refetch_cmd got v%b len%0d a%h want v1 len8 a002af0",
                         mem_cmd_valid, mem_len, mem_addr);
    end
    n = 0;
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (ic_wstrobe_d) begin
        n++;
        if (n == 8) ic_pull = 0;
      end
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL refetch_strobes got %0d want 8", n); end
    idle_inputs(); cyc();
  endtask

  initial begin
    test_reset();
    test_refill();
    test_data_load();
    test_word_store();
    test_cmd_stall();
    test_arbitration();
    test_reset_mid_replay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
